// File: rtl/q_pkg.sv
// Shared fixed-point definitions and streaming-stage types.
// The fixed-point macros are defined here once so that every stage
// compiled after this package sees the same Q-format.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`define FIXED_FRAC  8
`define FIXED_MAX   16'sh7FFF
`define FIXED_MIN   16'sh8000
`endif

package q_pkg;

  // Two-phase streaming stage: ACC collects beats, DONE presents a result.
  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } stream_state_e;

endpackage

// File: rtl/q_add.sv
// Saturating signed fixed-point adder; reports when the result was clamped.
module q_add
  import q_pkg::*;
(
  input  logic signed [`FIXED_WIDTH-1:0] a,
  input  logic signed [`FIXED_WIDTH-1:0] b,
  output logic signed [`FIXED_WIDTH-1:0] sum,
  output logic                           sat
);

  logic signed [`FIXED_WIDTH:0] sum_wide;

  assign sum_wide = {a[`FIXED_WIDTH-1], a} + {b[`FIXED_WIDTH-1], b};

  // Overflow when the extra sign bit disagrees with the result sign bit.
  always_comb begin
    sum = sum_wide[`FIXED_WIDTH-1:0];
    sat = 1'b0;
    if (sum_wide[`FIXED_WIDTH] != sum_wide[`FIXED_WIDTH-1]) begin
      sat = 1'b1;
      sum = sum_wide[`FIXED_WIDTH] ? `FIXED_MIN : `FIXED_MAX;
    end
  end

endmodule

// File: rtl/q_dot_acc.sv
// Streaming fixed-point dot-product accumulator.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid/data are held by the source until that edge, and ready
// never depends combinationally on valid (it is derived from state only).
module q_dot_acc
  import q_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [`FIXED_WIDTH-1:0] in_a,
  input  logic signed [`FIXED_WIDTH-1:0] in_b,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [`FIXED_WIDTH-1:0] out_data,
  output logic        [CNT_W-1:0]        out_count,
  output logic                           out_sat
);

  localparam int W = `FIXED_WIDTH;
  localparam logic signed [2*W-1:0] MAX_WIDE = {{W{1'b0}}, `FIXED_MAX};
  localparam logic signed [2*W-1:0] MIN_WIDE = {{W{1'b1}}, `FIXED_MIN};
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  stream_state_e state, state_next;

  logic signed [W-1:0]   acc, acc_next, prod_clamped;
  logic [CNT_W-1:0]      count;
  logic                  sat, prod_sat, sum_sat, beat;
  logic signed [2*W-1:0] prod_full, prod_shift;

  assign beat       = in_valid && in_ready;
  assign prod_full  = in_a * in_b;
  assign prod_shift = prod_full >>> `FIXED_FRAC;

  // Clamp the rescaled product into the Q-format range.
  always_comb begin
    prod_clamped = prod_shift[W-1:0];
    prod_sat     = 1'b0;
    if (prod_shift > MAX_WIDE) begin
      prod_clamped = `FIXED_MAX;
      prod_sat     = 1'b1;
    end else if (prod_shift < MIN_WIDE) begin
      prod_clamped = `FIXED_MIN;
      prod_sat     = 1'b1;
    end
  end

  q_add u_add (
    .a   (acc),
    .b   (prod_clamped),
    .sum (acc_next),
    .sat (sum_sat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_next;
  end

  // Next state and handshake outputs, both pure functions of state.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
  end

  // Accumulator, beat counter and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (rst || (state == DONE && out_ready)) begin
      acc   <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else if (beat) begin
      acc   <= acc_next;
      if (count != '1) count <= count + CNT_ONE;
      sat   <= sat | prod_sat | sum_sat;
    end
  end

  assign out_data  = acc;
  assign out_count = count;
  assign out_sat   = sat;

endmodule

// File: tb/tb_q_dot_acc.sv
// Testbench for q_dot_acc: scenario tasks with a result scoreboard.
module tb_q_dot_acc;

  logic        clk, rst;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [15:0] out_count;
  logic        out_sat;

  // Scoreboard entry: {data, count, sat}
  logic [32:0] exp_q[$];

  int     n_vec  = 0;
  int     n_miss = 0;
  longint m_acc  = 0;
  int     m_cnt  = 0;
  logic   m_sat  = 1'b0;

  q_dot_acc #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint clamp16(input longint v, inout logic flag);
    if (v > 32767) begin
      flag = 1'b1;
      return 32767;
    end
    if (v < -32768) begin
      flag = 1'b1;
      return -32768;
    end
    return v;
  endfunction

  function automatic void model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_sat = 1'b0;
  endfunction

  // Drive one beat starting at a negedge; the model tracks the expected sums.
  task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic last);
    longint pa, pb, p;
    logic [15:0] acc16;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = (pa * pb) >>> 8;
    p  = clamp16(p, m_sat);
    m_acc = clamp16(m_acc + p, m_sat);
    if (m_cnt < 65535) m_cnt++;
    if (last) begin
      acc16 = m_acc[15:0];
      exp_q.push_back({acc16, 16'(m_cnt), m_sat});
      model_clear();
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = 16'($urandom_range(0, 65535));
    in_b     = 16'($urandom_range(0, 65535));
    in_last  = 1'($urandom_range(0, 1));
  endtask

  // Called at the negedge right after the last beat: the result must already be valid.
  task automatic check_result(input string name);
    logic [32:0] e;
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_miss++;
      $display("FAIL %s handshake: out_valid=%b in_ready=%b, required 1/0", name, out_valid, in_ready);
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL %s scoreboard: no expected entry, got data=%h count=%0d", name, out_data, out_count);
    end else begin
      e = exp_q.pop_front();
      if ({out_data, out_count, out_sat} !== e) begin
        n_miss++;
        $display("FAIL %s result: data=%h count=%0d sat=%b, required data=%h count=%0d sat=%b",
                 name, out_data, out_count, out_sat, e[32:17], e[16:1], e[0]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0 || out_count !== 16'h0 || out_sat !== 1'b0) begin
      n_miss++;
      $display("FAIL %s release: in_ready=%b out_valid=%b data=%h count=%0d sat=%b, required 1/0/0000/0/0",
               name, in_ready, out_valid, out_data, out_count, out_sat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_a = 16'h7FFF; in_b = 16'h7FFF; in_last = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0 || out_count !== 16'h0 || out_sat !== 1'b0) begin
      n_miss++;
      $display("FAIL reset: in_ready=%b out_valid=%b data=%h count=%0d sat=%b, required 1/0/0000/0/0",
               in_ready, out_valid, out_data, out_count, out_sat);
    end
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    send_beat(16'h0180, 16'h0200, 1'b0);
    send_beat(16'h0080, 16'hFC00, 1'b1);
    if (exp_q.size() != 0 && exp_q[0] !== {16'h0100, 16'd2, 1'b0}) begin
      n_miss++;
      $display("FAIL basic model: entry %h, required %h", exp_q[0], {16'h0100, 16'd2, 1'b0});
    end
    check_result("basic");
  endtask

  task automatic test_product_sat();
    send_beat(16'h6400, 16'h0200, 1'b1);
    check_result("product_sat");
  endtask

  task automatic test_partial_sat();
    for (int i = 0; i < 4; i++) send_beat(16'h4000, 16'h0100, i == 3);
    check_result("partial_sat_pos");
    for (int i = 0; i < 4; i++) send_beat(16'hC000, 16'h0100, i == 3);
    check_result("partial_sat_neg");
  endtask

  task automatic test_hold();
    logic [32:0] e;
    send_beat(16'h0300, 16'h0100, 1'b0);
    send_beat(16'hFF00, 16'h0080, 1'b1);
    e = exp_q.pop_front();
    in_valid = 1'b1;
    in_a = 16'h1234; in_b = 16'h2345; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_data, out_count, out_sat} !== e) begin
        n_miss++;
        $display("FAIL hold cycle %0d: in_ready=%b out_valid=%b data=%h count=%0d sat=%b, required 0/1 %h/%0d/%b",
                 i, in_ready, out_valid, out_data, out_count, out_sat, e[32:17], e[16:1], e[0]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0 || out_count !== 16'h0) begin
      n_miss++;
      $display("FAIL hold release: in_ready=%b out_valid=%b data=%h count=%0d, required 1/0/0000/0",
               in_ready, out_valid, out_data, out_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [32:0] e;
    send_beat(16'h0200, 16'h0300, 1'b0);
    send_beat(16'h0100, 16'h0500, 1'b0);
    model_clear();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0 || out_count !== 16'h0 || out_sat !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b data=%h count=%0d sat=%b, required 1/0/0000/0/0",
               in_ready, out_valid, out_data, out_count, out_sat);
    end
    send_beat(16'h0100, 16'h0100, 1'b1);
    check_result("after_reset_mid");
    // Reset while a result is waiting in DONE discards it.
    send_beat(16'h0500, 16'h0100, 1'b1);
    e = exp_q.pop_front();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0 || out_count !== 16'h0) begin
      n_miss++;
      $display("FAIL reset_done: in_ready=%b out_valid=%b data=%h count=%0d (dropped %h), required 1/0/0000/0",
               in_ready, out_valid, out_data, out_count, e);
    end
  endtask

  task automatic test_random();
    int len;
    logic [15:0] a, b;
    for (int v = 0; v < 12; v++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          a = 16'($urandom_range(0, 65535));
          b = 16'($urandom_range(0, 65535));
        end else begin
          a = 16'($signed(11'($urandom_range(0, 2047))));
          b = 16'($signed(11'($urandom_range(0, 2047))));
        end
        send_beat(a, b, i == len - 1);
      end
      check_result("random");
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_product_sat();
    test_partial_sat();
    test_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
